// File: rtl/backing_memory.sv
// Word-organised main memory behind the data cache: 4-word block reads and
// single-word writes, one request in flight, fixed LATENCY-cycle access.
module backing_memory #(
  parameter int ADDR_W      = 10,
  parameter int BLOCK_WORDS = 4,
  parameter int LATENCY     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  input  logic                      req_write,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [31:0]               req_wdata,
  output logic                      req_ready,
  output logic                      resp_valid,
  output logic [32*BLOCK_WORDS-1:0] resp_rdata,
  output logic                      busy
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam int DEPTH = 2 ** ADDR_W;

  generate
    if (BLOCK_WORDS != 4) begin : g_bad_block
      $error("backing_memory: BLOCK_WORDS must be 4");
    end
    if (LATENCY < 1) begin : g_bad_latency
      $error("backing_memory: LATENCY must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t                      state;
  logic [CNT_W-1:0]            cnt;
  logic                        write_p0;
  logic [ADDR_W-1:0]           addr_p0;
  logic [31:0]                 wdata_p0;
  logic                        accept;
  logic                        commit;
  logic [32*BLOCK_WORDS-1:0]   rd_block;

  logic [31:0] mem [DEPTH];

  // Block-aligned base: the low two address bits select a word inside a block.
  function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

  function automatic logic [ADDR_W-1:0] block_word(input logic [ADDR_W-1:0] a,
                                                   input int              i);
    return block_base(a) | ADDR_W'(i);
  endfunction

  assign accept     = (state == IDLE) && req_valid;
  assign commit     = (state == WAIT) && (cnt == '0);

  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign resp_valid = (state == RESP);

  // Stage p0: request capture at acceptance; held untouched until the next accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p0  <= req_addr;
      wdata_p0 <= req_wdata;
    end
  end

  // Gather the four aligned words of the captured block.
  always_comb begin
    rd_block = '0;
    for (int i = 0; i < BLOCK_WORDS; i++) begin
      rd_block[32*i +: 32] = mem[block_word(addr_p0, i)];
    end
  end

  // State is IDLE whenever reset is low, so a pending write never commits.
  always_ff @(posedge clk) begin
    if (commit && write_p0) begin
      mem[addr_p0] <= wdata_p0;
    end
  end

  // Stage p1: control FSM and read-data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      write_p0   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            write_p0 <= req_write;
            cnt      <= CNT_LOAD;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            if (!write_p0) begin
              resp_rdata <= rd_block;
            end
            state <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_backing_memory.sv
// Scoreboard bench for backing_memory: three instances at LATENCY 4, 1 and 7,
// directed stimulus pushes expected responses, a monitor pops and compares.
module tb_backing_memory;

  localparam int NDUT = 3;

  logic         clk;
  logic         rst_n      [NDUT];
  logic         req_valid  [NDUT];
  logic         req_write  [NDUT];
  logic [9:0]   req_addr   [NDUT];
  logic [31:0]  req_wdata  [NDUT];
  logic         req_ready  [NDUT];
  logic         resp_valid [NDUT];
  logic [127:0] resp_rdata [NDUT];
  logic         busy       [NDUT];

  typedef struct {
    int           dut;
    logic [127:0] data;
    logic [127:0] mask;
    int           due;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  localparam logic [127:0] ALL  = {128{1'b1}};
  localparam logic [127:0] NONE = 128'd0;
  localparam logic [127:0] W0   = {96'd0, 32'hFFFFFFFF};
  localparam logic [127:0] W1   = {64'd0, 32'hFFFFFFFF, 32'd0};
  localparam logic [127:0] W01  = {64'd0, 64'hFFFFFFFF_FFFFFFFF};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  genvar g;
  generate
    for (g = 0; g < NDUT; g++) begin : g_dut
      backing_memory #(
        .ADDR_W     (10),
        .BLOCK_WORDS(4),
        .LATENCY    ((g == 0) ? 4 : ((g == 1) ? 1 : 7))
      ) dut (
        .clk       (clk),
        .rst_n     (rst_n[g]),
        .req_valid (req_valid[g]),
        .req_write (req_write[g]),
        .req_addr  (req_addr[g]),
        .req_wdata (req_wdata[g]),
        .req_ready (req_ready[g]),
        .resp_valid(resp_valid[g]),
        .resp_rdata(resp_rdata[g]),
        .busy      (busy[g])
      );
    end
  endgenerate

  function automatic int lat(input int d);
    return (d == 0) ? 4 : ((d == 1) ? 1 : 7);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request; optionally record the expected response.
  task automatic issue(input int d, input logic wr, input logic [9:0] a,
                       input logic [31:0] wd, input logic [127:0] ed,
                       input logic [127:0] em, input bit track);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (req_ready[d] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      fails++;
      $display("FAIL ready_timeout dut%0d: req_ready stayed %b, expected 1", d, req_ready[d]);
      return;
    end
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    @(negedge clk);
    req_valid[d] = 1'b0;
    req_wdata[d] = $urandom;
    if (track) begin
      e.dut  = d;
      e.data = ed;
      e.mask = em;
      e.due  = cyc + lat(d);
      sbq.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
  endtask

  // Monitor: every response pulse must match the oldest pending entry for its instance.
  always @(negedge clk) begin
    int   idx;
    exp_t e;
    for (int d = 0; d < NDUT; d++) begin
      if (resp_valid[d] === 1'b1) begin
        idx = -1;
        for (int i = 0; i < sbq.size(); i++) begin
          if (sbq[i].dut == d) begin
            idx = i;
            break;
          end
        end
        checks++;
        if (idx < 0) begin
          fails++;
          $display("FAIL unexpected_resp dut%0d: resp_valid=1 at cycle %0d, expected 0", d, cyc);
        end else begin
          e = sbq[idx];
          sbq.delete(idx);
          if (cyc != e.due || (((resp_rdata[d] ^ e.data) & e.mask) !== 128'd0)) begin
            fails++;
            $display("FAIL resp dut%0d: cycle %0d data %h, expected cycle %0d data %h mask %h",
                     d, cyc, resp_rdata[d], e.due, e.data, e.mask);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    for (int d = 0; d < NDUT; d++) begin
      rst_n[d] = 1'b0;
      req_valid[d] = 1'b0;
      req_write[d] = 1'b0;
      req_addr[d] = '0;
      req_wdata[d] = '0;
    end

    // Reset with random inputs
    repeat (4) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        req_valid[d] = 1'($urandom);
        req_write[d] = 1'($urandom);
        req_addr[d]  = 10'($urandom);
        req_wdata[d] = $urandom;
      end
    end
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("rst_ready%0d", d), 128'(req_ready[d]), 128'd1);
      check($sformatf("rst_busy%0d", d), 128'(busy[d]), 128'd0);
      check($sformatf("rst_resp_valid%0d", d), 128'(resp_valid[d]), 128'd0);
      check($sformatf("rst_rdata%0d", d), resp_rdata[d], 128'd0);
      req_valid[d] = 1'b0;
      rst_n[d] = 1'b1;
    end

    // Write then read on LATENCY=4
    issue(0, 1'b1, 10'h005, 32'hDEADBEEF, NONE, NONE, 1'b1);
    issue(0, 1'b0, 10'h004, 32'h0, {64'd0, 32'hDEADBEEF, 32'd0}, W1, 1'b1);
    drain();

    // Held request: accepted at E0 and E6 only
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = 10'h010;
    req_wdata[0] = 32'h0BADF00D;
    base = cyc + 1;
    sbq.push_back('{dut: 0, data: NONE, mask: NONE, due: base + 4});
    sbq.push_back('{dut: 0, data: NONE, mask: NONE, due: base + 10});
    repeat (12) @(negedge clk);
    req_valid[0] = 1'b0;
    drain();
    issue(0, 1'b0, 10'h013, 32'h0, {96'd0, 32'h0BADF00D}, W0, 1'b1);
    drain();

    // Top block of memory
    issue(0, 1'b1, 10'h3FC, 32'h11111111, NONE, NONE, 1'b1);
    issue(0, 1'b1, 10'h3FD, 32'h22222222, NONE, NONE, 1'b1);
    issue(0, 1'b1, 10'h3FE, 32'h33333333, NONE, NONE, 1'b1);
    issue(0, 1'b1, 10'h3FF, 32'h44444444, NONE, NONE, 1'b1);
    issue(0, 1'b0, 10'h3FE, 32'h0, 128'h44444444_33333333_22222222_11111111, ALL, 1'b1);
    issue(0, 1'b1, 10'h200, 32'h12345678, 128'h44444444_33333333_22222222_11111111, ALL, 1'b1);
    drain();

    // Reset in the middle of a write
    issue(0, 1'b1, 10'h020, 32'h00000000, NONE, NONE, 1'b1);
    issue(0, 1'b1, 10'h021, 32'h5A5A5A5A, NONE, NONE, 1'b1);
    drain();
    issue(0, 1'b1, 10'h020, 32'hCAFEF00D, NONE, NONE, 1'b0);
    @(negedge clk);
    rst_n[0] = 1'b0;
    @(negedge clk);
    check("abort_ready", 128'(req_ready[0]), 128'd1);
    check("abort_busy", 128'(busy[0]), 128'd0);
    rst_n[0] = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_no_resp", 128'(resp_valid[0]), 128'd0);
    issue(0, 1'b0, 10'h020, 32'h0, {64'd0, 32'h5A5A5A5A, 32'h00000000}, W01, 1'b1);
    drain();

    // Latency sweep: LATENCY=1 and LATENCY=7
    for (int d = 1; d < NDUT; d++) begin
      issue(d, 1'b1, 10'h100, 32'hA0A0A0A0 + d, NONE, NONE, 1'b1);
      issue(d, 1'b1, 10'h101, 32'hB1B1B1B1, NONE, NONE, 1'b1);
      issue(d, 1'b1, 10'h102, 32'hC2C2C2C2, NONE, NONE, 1'b1);
      issue(d, 1'b1, 10'h103, 32'hD3D3D3D3, NONE, NONE, 1'b1);
      issue(d, 1'b0, 10'h101, 32'h0,
            {32'hD3D3D3D3, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0 + 32'(d)}, ALL, 1'b1);
      issue(d, 1'b1, 10'h102, 32'h77777777,
            {32'hD3D3D3D3, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0 + 32'(d)}, ALL, 1'b1);
      issue(d, 1'b0, 10'h103, 32'h0,
            {32'hD3D3D3D3, 32'h77777777, 32'hB1B1B1B1, 32'hA0A0A0A0 + 32'(d)}, ALL, 1'b1);
      drain();
    end

    // Any entry still queued never got its response
    while (sbq.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL missing_resp dut%0d: no response, expected one at cycle %0d",
               sbq[0].dut, sbq[0].due);
      void'(sbq.pop_front());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/backing_memory.md
# backing_memory

Word-organised main memory behind the data cache (`cache_top`). It serves cache line refills as 4-word block reads and write-through stores as single-word writes, using a single-outstanding valid/ready request and a one-cycle response pulse. Access latency is a fixed, parameterised number of cycles, which exercises the cache stall path under realistic miss penalties. Its address space matches the processor's 10-bit data word address.

## Interface
Parameters:
- `ADDR_W`, 10, word-address width; depth is 2^ADDR_W 32-bit words.
- `BLOCK_WORDS`, 4, words per refill block; fixed at 4 in this revision.
- `LATENCY`, 4, cycles from request acceptance to response; legal range is at least 1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_write`  in  1  1 = single-word write, 0 = block read.
- `req_addr`  in  ADDR_W  word address; reads use `req_addr[ADDR_W-1:2]` (block aligned).
- `req_wdata`  in  32  write data; ignored for reads.
- `req_ready`  out  1  high only in IDLE; a request is accepted on an edge where `req_valid && req_ready`.
- `resp_valid`  out  1  one-cycle pulse marking completion of a read or write.
- `resp_rdata`  out  128  read block; word 0 in `[31:0]`, word 3 in `[127:96]`.
- `busy`  out  1  high in WAIT and RESP.

## Operation
- FSM states: IDLE, WAIT, RESP.
  - IDLE: `req_ready`=1. On accept, capture `addr`/`write`/`wdata`, load the counter with `LATENCY-1`, and go to WAIT.
  - WAIT: decrement the counter each cycle. When the counter is 0, go to RESP.
    - A write commits `mem[addr]` on this same edge.
    - A read loads `resp_rdata` from the 4 aligned words on this same edge.
  - RESP: `resp_valid`=1 for exactly one cycle, then IDLE.
- Requests arriving while not in IDLE are ignored, not queued. A `req_valid` held high across busy cycles is accepted once only, on the first IDLE edge, and re-accepted only if still high in IDLE afterwards.
- Reads return the contents as of the response edge, including every previously completed write.
- `resp_rdata` holds its value until the next read response. A write response leaves it unchanged.
- Counter width is `$clog2(LATENCY)`, minimum 1 bit. No wrap-around is used.
- Address arithmetic:
  - Block base = `{req_addr[ADDR_W-1:2], 2'b00}`; word i = base + i, for i = 0..3.
  - Blocks never straddle the top of memory, so addresses 0x3FC..0x3FF form the last block.
- Memory array is not reset. Contents are undefined until written; the bench writes before reading.
- Reset asserted mid-operation:
  - Aborts immediately and returns to IDLE.
  - A write not yet committed is dropped; no partial commit.
  - No `resp_valid` is produced.

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `busy`=0, `resp_rdata`=0, counter=0.
- Request accepted at edge E0. Commit or read capture happens at edge E(LATENCY). `resp_valid` is high between E(LATENCY) and E(LATENCY+1).
- `req_ready` returns high after E(LATENCY+1). The earliest next accept is edge E(LATENCY+2).
- Throughput: one request per LATENCY+2 cycles.
- With `LATENCY`=1, WAIT lasts one cycle (counter loaded with 0).
- All outputs are registered or decoded from state only. There is no combinational path from `req_*` to any output.

## Test plan
- Reset: hold `rst_n`=0 with random inputs -> `req_ready`=1, `busy`=0, `resp_valid`=0, `resp_rdata`=0.
- Write then read: write 0xDEADBEEF at 0x005, then read at 0x004 -> `resp_valid` 4 cycles after each accept, and `resp_rdata[63:32]`=0xDEADBEEF.
- Held request: `req_valid`=1, `req_write`=1, addr 0x010 held for 12 cycles -> accepts at E0 and E6 only, with exactly 2 `resp_valid` pulses.
- Top block: write 0x11111111..0x44444444 to 0x3FC..0x3FF, then read 0x3FE -> `resp_rdata`=0x44444444_33333333_22222222_11111111.
- Reset mid-write:
  - Write 0xCAFEF00D to 0x020, pulse `rst_n` low 2 cycles after accept.
  - Then read 0x020 -> `[31:0]` keeps its prior value 0x0, with no `resp_valid` for the aborted write.
- Latency sweep: `LATENCY`=1 and 7 -> `resp_valid` exactly 1 and 7 cycles after accept; write response leaves `resp_rdata` unchanged.
